// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------
// adder_pkg: shared FSM encoding and default width for serial_adder
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ---------------------------------------------------------------
// full_adder: one-bit combinational adder cell
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------
// serial_adder: bit-serial a+b+cin, LSB first, one bit per clock
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              fa_s;
  logic              fa_co;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        // On the MSB edge carry_q is the carry into the MSB, giving ovf directly
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------
// tb_serial_adder: randomized self-checking bench, WIDTH=8 and WIDTH=3
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v8, rdy8, ov8, or8, ci8, co8, of8, bz8;
  logic [7:0] a8, b8, s8;
  logic       v3, rdy3, ov3, or3, ci3, co3, of3, bz3;
  logic [2:0] a3, b3, s3;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(ci8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .a(a3), .b(b3), .cin(ci3), .out_valid(ov3), .out_ready(or3),
    .sum(s3), .cout(co3), .ovf(of3), .busy(bz3)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: {ovf, cout, sum} from unsigned and signed integer arithmetic
  function automatic logic [31:0] ref_add(input int w, input int a, input int b, input int c);
    int u, sa, sb, sr, m;
    logic [31:0] r;
    m  = 1 << w;
    u  = a + b + c;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sa + sb + c;
    r  = 32'(u % m);
    r[w]     = (u >= m);
    r[w + 1] = (sr >= m / 2) || (sr < -(m / 2));
    return r;
  endfunction

  task automatic scramble8();
    v8  = 1'($urandom_range(0, 1));
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    ci8 = 1'($urandom_range(0, 1));
  endtask

  // Caller is positioned between edges with the DUT in IDLE
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
    logic [31:0] e;
    int lat;
    e = ref_add(8, int'(a), int'(b), int'(c));
    chk("in_ready_idle", 32'(rdy8), 32'd1);
    v8 = 1'b1; a8 = a; b8 = b; ci8 = c;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(bz8), 32'd1);
    lat = 0;
    while (!ov8 && lat < 40) begin
      scramble8();
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("sum", 32'(s8), 32'(e[7:0]));
    chk("cout", 32'(co8), 32'(e[8]));
    chk("ovf", 32'(of8), 32'(e[9]));
    for (int i = 0; i < hold; i++) begin
      scramble8();
      @(posedge clk); #1;
      chk("hold_valid", 32'(ov8), 32'd1);
      chk("hold_in_ready", 32'(rdy8), 32'd0);
      chk("hold_result", 32'({of8, co8, s8}), 32'(e[9:0]));
    end
    v8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("release_valid", 32'(ov8), 32'd0);
    chk("release_in_ready", 32'(rdy8), 32'd1);
    chk("idle_result_held", 32'({of8, co8, s8}), 32'(e[9:0]));
  endtask

  logic [31:0] exp3_q[$];
  logic [31:0] e3;
  int          n3_res = 0;

  always @(negedge clk) begin
    if (ov3) begin
      if (exp3_q.size() == 0) begin
        chk("w3_unexpected_result", 32'd1, 32'd0);
      end else begin
        e3 = exp3_q.pop_front();
        chk("w3_result", 32'({of3, co3, s3}), 32'(e3[4:0]));
        n3_res++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc, misses, bad_tp, r, ok;
    rst_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b0;
    v3 = 1'b0; a3 = '0; b3 = '0; ci3 = 1'b0; or3 = 1'b1;
    #3;
    chk("rst_in_ready", 32'(rdy8), 32'd1);
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_result", 32'({of8, co8, s8}), 32'd0);
    #20;
    rst_n = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 1);
    op8(8'h7F, 8'h01, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    op8(8'h80, 8'h80, 1'b0, 2);
    op8(8'h12, 8'h34, 1'b1, 5);
    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // Abort mid-operation with an asynchronous reset between edges
    v8 = 1'b1; a8 = 8'h55; b8 = 8'h33; ci8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(rdy8), 32'd1);
    chk("abort_busy", 32'(bz8), 32'd0);
    chk("abort_out_valid", 32'(ov8), 32'd0);
    chk("abort_result", 32'({of8, co8, s8}), 32'd0);
    #3;
    rst_n = 1'b1;
    op8(8'h01, 8'h02, 1'b0, 0);

    // Exhaustive WIDTH=3, back-to-back with out_ready tied high
    last_acc = -1; misses = 0; bad_tp = 0;
    for (int k = 0; k < 128; k++) begin
      v3 = 1'b1; a3 = 3'(k); b3 = 3'(k >> 3); ci3 = 1'(k >> 6);
      ok = 0;
      for (int t = 0; t < 20; t++) begin
        r = int'(rdy3);
        @(posedge clk); #1;
        if (r != 0) begin
          ok = 1;
          break;
        end
      end
      if (ok != 0) begin
        exp3_q.push_back(ref_add(3, k & 7, (k >> 3) & 7, (k >> 6) & 1));
        if (last_acc >= 0 && (cyc - last_acc) != 5) bad_tp++;
        last_acc = cyc;
      end else begin
        misses++;
      end
    end
    v3 = 1'b0;
    for (int t = 0; t < 20 && exp3_q.size() != 0; t++) @(posedge clk);
    @(posedge clk); #1;
    chk("w3_accept_timeouts", 32'(misses), 32'd0);
    chk("w3_throughput_violations", 32'(bad_tp), 32'd0);
    chk("w3_result_count", 32'(n3_res), 32'd128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
